// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM state encoding and BCD digit format.
package stopwatch_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  typedef struct packed {
    bcd_t hundreds;
    bcd_t tens;
    bcd_t ones;
  } digits_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Bundle of request, counter and display signals between the stopwatch controller and its surroundings.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic       start_stop;
  logic       lap_clr;
  bcd_t       ones;
  bcd_t       tens;
  bcd_t       hundreds;
  logic       cnt_en;
  logic       cnt_clr;
  bcd_t       disp_ones;
  bcd_t       disp_tens;
  bcd_t       disp_hundreds;
  logic       lap_frozen;
  logic [1:0] state;
  logic       overflow;

  modport master (
    output start_stop, lap_clr, ones, tens, hundreds,
    input  cnt_en, cnt_clr, disp_ones, disp_tens, disp_hundreds, lap_frozen, state, overflow
  );

  modport slave (
    input  start_stop, lap_clr, ones, tens, hundreds,
    output cnt_en, cnt_clr, disp_ones, disp_tens, disp_hundreds, lap_frozen, state, overflow
  );

endinterface

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Free-running divider that yields one tick every TICK_DIV clocks while run is high and holds otherwise.
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap controller driving an external BCD counter.
// Define STOPWATCH_SATURATE_EN to halt at 999 instead of wrapping.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);

  state_t  state_q, state_d;
  logic    tick;
  logic    clear_req;
  logic    lap_toggle;
  logic    cnt_clr_q;
  logic    lap_frozen_q;
  digits_t lap_q;
  digits_t live;
  logic    at_max;

  assign live   = {bus.hundreds, bus.tens, bus.ones};
  assign at_max = (bus.hundreds == BCD_MAX) && (bus.tens == BCD_MAX) && (bus.ones == BCD_MAX);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (state_q == ST_RUN),
    .clear (clear_req),
    .tick  (tick)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    bus.cnt_en = 1'b0;
    clear_req  = 1'b0;
    lap_toggle = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_stop)   state_d   = ST_RUN;
        else if (bus.lap_clr) clear_req = 1'b1;
      end
      ST_RUN: begin
        if (bus.start_stop)   state_d    = ST_PAUSE;
        else if (bus.lap_clr) lap_toggle = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
        // Saturation outranks a same-cycle pause so the counter can never step past 999.
        if (tick && at_max) state_d    = ST_HALT;
        else                bus.cnt_en = tick;
`else
        bus.cnt_en = tick;
`endif
      end
      ST_PAUSE: begin
        if (bus.start_stop) begin
          state_d = ST_RUN;
        end else if (bus.lap_clr) begin
          state_d   = ST_IDLE;
          clear_req = 1'b1;
        end
      end
      ST_HALT: begin
        if (bus.lap_clr) begin
          state_d   = ST_IDLE;
          clear_req = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: lap registers are reset so a stale lap can never be shown after power-up.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_clr_q    <= 1'b1;
      lap_frozen_q <= 1'b0;
      lap_q        <= '0;
    end else begin
      state_q   <= state_d;
      cnt_clr_q <= clear_req;
      if (clear_req) begin
        lap_frozen_q <= 1'b0;
      end else if (lap_toggle) begin
        lap_frozen_q <= !lap_frozen_q;
        if (!lap_frozen_q) lap_q <= live;
      end
    end
  end

  assign bus.cnt_clr       = cnt_clr_q;
  assign bus.lap_frozen    = lap_frozen_q;
  assign bus.state         = state_q;
  assign bus.disp_hundreds = lap_frozen_q ? lap_q.hundreds : bus.hundreds;
  assign bus.disp_tens     = lap_frozen_q ? lap_q.tens     : bus.tens;
  assign bus.disp_ones     = lap_frozen_q ? lap_q.ones     : bus.ones;

`ifdef STOPWATCH_SATURATE_EN
  assign bus.overflow = (state_q == ST_HALT);
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4: vector table through a scoreboard plus corner sequences.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ss;
    logic        lc;
    logic [11:0] dig;
    logic [1:0]  e_state;
    logic        e_en;
    logic        e_clr;
    logic        e_frz;
    logic [11:0] e_disp;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(logic r, logic ss, logic lc, logic [11:0] dig, logic [1:0] st,
                              logic en, logic clr, logic frz, logic [11:0] disp);
    vec_t v;
    v.rst = r; v.ss = ss; v.lc = lc; v.dig = dig;
    v.e_state = st; v.e_en = en; v.e_clr = clr; v.e_frz = frz; v.e_disp = disp; v.e_ovf = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ss, input logic lc, input logic [11:0] dig);
    rst              = r;
    sw_if.start_stop = ss;
    sw_if.lap_clr    = lc;
    sw_if.hundreds   = dig[11:8];
    sw_if.tens       = dig[7:4];
    sw_if.ones       = dig[3:0];
  endtask

  task automatic step(input logic r, input logic ss, input logic lc, input logic [11:0] dig);
    @(negedge clk);
    drive(r, ss, lc, dig);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    logic [11:0] disp;
    @(negedge clk);
    drive(v.rst, v.ss, v.lc, v.dig);
    exp_q.push_back(v);
    #1;
    e    = exp_q.pop_front();
    disp = {sw_if.disp_hundreds, sw_if.disp_tens, sw_if.disp_ones};
    check($sformatf("v%0d state", idx), 16'(sw_if.state), 16'(e.e_state));
    check($sformatf("v%0d cnt_en", idx), 16'(sw_if.cnt_en), 16'(e.e_en));
    check($sformatf("v%0d cnt_clr", idx), 16'(sw_if.cnt_clr), 16'(e.e_clr));
    check($sformatf("v%0d lap_frozen", idx), 16'(sw_if.lap_frozen), 16'(e.e_frz));
    check($sformatf("v%0d disp", idx), 16'(disp), 16'(e.e_disp));
    check($sformatf("v%0d overflow", idx), 16'(sw_if.overflow), 16'(e.e_ovf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset release, start, 12 RUN clocks with three ticks, pause at prescaler=2, resume.
    vecs.push_back(mk(1, 0, 0, 12'h000, 2'b00, 0, 1, 0, 12'h000));
    vecs.push_back(mk(1, 1, 0, 12'h000, 2'b00, 0, 0, 0, 12'h000));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(1, 0, 0, 12'h000, 2'b01, 0, 0, 0, 12'h000));
      vecs.push_back(mk(1, 0, 0, 12'h000, 2'b01, 0, 0, 0, 12'h000));
      vecs.push_back(mk(1, 0, 0, 12'h000, 2'b01, 0, 0, 0, 12'h000));
      vecs.push_back(mk(1, 0, 0, 12'h000, 2'b01, 1, 0, 0, 12'h000));
    end
    vecs.push_back(mk(1, 0, 0, 12'h000, 2'b01, 0, 0, 0, 12'h000));
    vecs.push_back(mk(1, 0, 0, 12'h000, 2'b01, 0, 0, 0, 12'h000));
    vecs.push_back(mk(1, 1, 0, 12'h000, 2'b01, 0, 0, 0, 12'h000));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(1, 0, 0, 12'h000, 2'b10, 0, 0, 0, 12'h000));
    vecs.push_back(mk(1, 1, 0, 12'h000, 2'b10, 0, 0, 0, 12'h000));
    vecs.push_back(mk(1, 0, 0, 12'h000, 2'b01, 1, 0, 0, 12'h000));
    // Lap capture at 0/4/7 while live digits advance, then release.
    vecs.push_back(mk(1, 0, 1, 12'h047, 2'b01, 0, 0, 0, 12'h047));
    vecs.push_back(mk(1, 0, 0, 12'h048, 2'b01, 0, 0, 1, 12'h047));
    vecs.push_back(mk(1, 0, 0, 12'h050, 2'b01, 0, 0, 1, 12'h047));
    vecs.push_back(mk(1, 0, 0, 12'h051, 2'b01, 1, 0, 1, 12'h047));
    vecs.push_back(mk(1, 0, 1, 12'h052, 2'b01, 0, 0, 1, 12'h047));
    vecs.push_back(mk(1, 0, 0, 12'h052, 2'b01, 0, 0, 0, 12'h052));
    // Simultaneous requests from RUN, then clear from PAUSE.
    vecs.push_back(mk(1, 1, 1, 12'h052, 2'b01, 0, 0, 0, 12'h052));
    vecs.push_back(mk(1, 0, 0, 12'h052, 2'b10, 0, 0, 0, 12'h052));
    vecs.push_back(mk(1, 0, 1, 12'h052, 2'b10, 0, 0, 0, 12'h052));
    vecs.push_back(mk(1, 0, 0, 12'h052, 2'b00, 0, 1, 0, 12'h052));
    vecs.push_back(mk(1, 0, 0, 12'h052, 2'b00, 0, 0, 0, 12'h052));

    drive(1'b0, 1'b0, 1'b0, 12'h000);
    repeat (3) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Clear from PAUSE while a lap is frozen must also zero the prescaler.
    step(1, 1, 0, 12'h000);
    step(1, 0, 1, 12'h123);
    check("frz run state", 16'(sw_if.state), 16'h1);
    step(1, 1, 0, 12'h124);
    check("frz captured", 16'(sw_if.lap_frozen), 16'h1);
    check("frz disp", 16'({sw_if.disp_hundreds, sw_if.disp_tens, sw_if.disp_ones}), 16'h123);
    step(1, 0, 1, 12'h124);
    check("frz pause state", 16'(sw_if.state), 16'h2);
    step(1, 0, 0, 12'h124);
    check("frz clr state", 16'(sw_if.state), 16'h0);
    check("frz clr pulse", 16'(sw_if.cnt_clr), 16'h1);
    check("frz clr unfrozen", 16'(sw_if.lap_frozen), 16'h0);
    check("frz clr live disp", 16'({sw_if.disp_hundreds, sw_if.disp_tens, sw_if.disp_ones}), 16'h124);
    step(1, 1, 0, 12'h000);
    check("frz clr pulse end", 16'(sw_if.cnt_clr), 16'h0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 12'h999);
      check($sformatf("psc cleared en%0d", k), 16'(sw_if.cnt_en), 16'h0);
    end

    // Tick due with live digits 9/9/9.
    step(1, 0, 0, 12'h999);
`ifdef STOPWATCH_SATURATE_EN
    check("sat cnt_en", 16'(sw_if.cnt_en), 16'h0);
    step(1, 1, 0, 12'h999);
    check("sat state", 16'(sw_if.state), 16'h3);
    check("sat overflow", 16'(sw_if.overflow), 16'h1);
    check("sat halt cnt_en", 16'(sw_if.cnt_en), 16'h0);
    step(1, 0, 1, 12'h999);
    check("sat ss ignored", 16'(sw_if.state), 16'h3);
    step(1, 0, 0, 12'h000);
    check("sat clr state", 16'(sw_if.state), 16'h0);
    check("sat clr overflow", 16'(sw_if.overflow), 16'h0);
    check("sat clr pulse", 16'(sw_if.cnt_clr), 16'h1);
`else
    check("wrap cnt_en", 16'(sw_if.cnt_en), 16'h1);
    check("wrap state", 16'(sw_if.state), 16'h1);
    check("wrap overflow", 16'(sw_if.overflow), 16'h0);
    step(1, 0, 0, 12'h000);
    check("wrap stays run", 16'(sw_if.state), 16'h1);
    step(1, 1, 0, 12'h000);
    step(1, 0, 1, 12'h000);
    step(1, 0, 0, 12'h000);
    check("wrap clr state", 16'(sw_if.state), 16'h0);
    check("wrap clr pulse", 16'(sw_if.cnt_clr), 16'h1);
`endif

    // Reset mid-RUN with a pending start_stop.
    step(1, 1, 0, 12'h000);
    step(1, 0, 0, 12'h000);
    step(1, 0, 0, 12'h000);
    step(1, 0, 0, 12'h000);
    step(0, 1, 0, 12'h000);
    check("rst pre tick", 16'(sw_if.cnt_en), 16'h1);
    step(0, 0, 0, 12'h000);
    check("rst cnt_en", 16'(sw_if.cnt_en), 16'h0);
    check("rst state", 16'(sw_if.state), 16'h0);
    check("rst cnt_clr", 16'(sw_if.cnt_clr), 16'h1);
    step(1, 0, 0, 12'h000);
    check("rst release clr", 16'(sw_if.cnt_clr), 16'h1);
    step(1, 0, 0, 12'h000);
    check("rst discard req", 16'(sw_if.state), 16'h0);
    check("rst clr end", 16'(sw_if.cnt_clr), 16'h0);
    check("rst idle cnt_en", 16'(sw_if.cnt_en), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000; clocks per count tick; legal range >= 2.
REQ-002 SHALL have port clk, input, 1; single rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1; reset, synchronous, active-low.
REQ-004 SHALL have port start_stop, input, 1; single-cycle, pre-debounced run/pause request.
REQ-005 SHALL have port lap_clr, input, 1; single-cycle, pre-debounced lap (in RUN) or clear (in PAUSE/IDLE/HALT) request.
REQ-006 SHALL have ports ones, tens, hundreds, input, 4 each; live BCD digits from the multi-decade counter.
REQ-007 SHALL have port cnt_en, output, 1; one-cycle count-enable pulse to the counter.
REQ-008 SHALL have port cnt_clr, output, 1; one-cycle registered clear pulse to the counter.
REQ-009 SHALL have ports disp_ones, disp_tens, disp_hundreds, output, 4 each; displayed digits, either live or frozen lap.
REQ-010 SHALL have port lap_frozen, output, 1; high while the display shows a captured lap.
REQ-011 SHALL have port state, output, 2; current FSM state: IDLE=00, RUN=01, PAUSE=10, HALT=11.
REQ-012 SHALL have port overflow, output, 1; high while in HALT.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN, PAUSE and HALT, with registered state.
REQ-014 IDLE: start_stop -> RUN; lap_clr -> cnt_clr pulse, remain IDLE.
REQ-015 RUN: the prescaler SHALL count 0..TICK_DIV-1 and wrap.
REQ-016 RUN: cnt_en SHALL be 1 combinationally, exactly in cycles where the prescaler equals TICK_DIV-1, giving 1 pulse per TICK_DIV clocks.
REQ-017 RUN: start_stop -> PAUSE; the prescaler SHALL hold its value, so that resuming continues the partial tick.
REQ-018 RUN: lap_clr SHALL toggle lap_frozen; on each 0->1 toggle, ones/tens/hundreds SHALL be captured into lap registers in that same cycle.
REQ-019 PAUSE: start_stop -> RUN.
REQ-020 PAUSE: lap_clr -> IDLE, with cnt_clr pulse, prescaler cleared to 0 and lap_frozen cleared.
REQ-021 cnt_en SHALL be 0 in every state except RUN.
REQ-022 cnt_clr SHALL assert in the cycle after an accepted clear request, for exactly 1 cycle.
REQ-023 disp_* SHALL equal the lap registers when lap_frozen=1, otherwise the live inputs (combinational, zero latency).
REQ-024 On simultaneous start_stop and lap_clr, start_stop SHALL take effect and lap_clr SHALL be ignored.
REQ-025 The clear path SHALL apply regardless of lap_frozen.

Reset
REQ-026 While rst=0 at a clock edge, the block SHALL set state=IDLE, prescaler=0, lap_frozen=0, lap registers=0 and overflow=0.
REQ-027 The cnt_clr register SHALL reset to 1, so the counter clears in the first cycle after reset release.
REQ-028 Reset asserted mid-RUN SHALL suppress cnt_en in the following cycle and SHALL discard any pending request.

Configuration
REQ-029 Macro STOPWATCH_SATURATE_EN SHALL compile the saturate-at-max feature in or out.
REQ-030 With STOPWATCH_SATURATE_EN defined: in RUN, when a tick is due and the live digits read 9/9/9, cnt_en SHALL be suppressed and the FSM SHALL move to HALT with overflow=1.
REQ-031 HALT: start_stop SHALL be ignored; lap_clr -> IDLE with cnt_clr pulse, overflow=0 and lap_frozen=0.
REQ-032 Without STOPWATCH_SATURATE_EN: the counter wraps 999->000 through normal cnt_en, HALT SHALL be unreachable, and overflow SHALL be tied to 0.

Structure
REQ-033 Package stopwatch_pkg SHALL hold the state encoding constants, the BCD digit width (4) and the BCD max digit (9).
REQ-034 The prescaler SHALL be the sub-module tick_prescaler, with ports clk, rst, run, clear, tick and a TICK_DIV parameter.
REQ-035 The FSM, lap capture and display mux SHALL reside in stopwatch_ctrl.

Verification (TICK_DIV=4)
REQ-036 Release reset, then start_stop -> cnt_clr=1 in cycle 1 after release; cnt_en pulses every 4th clock, and 12 clocks in RUN give 3 pulses.
REQ-037 In RUN with prescaler=2, start_stop, wait 10 clocks, then start_stop again -> no cnt_en while paused, and first cnt_en 1 clock after resume.
REQ-038 Live digits 0/4/7 (hundreds/tens/ones = 0,4,7), then lap_clr -> disp_* frozen at 0,4,7 while the live digits advance; a second lap_clr returns to live display.
REQ-039 In PAUSE, lap_clr -> cnt_clr high for exactly 1 cycle, state=00 and lap_frozen=0; start_stop and lap_clr in the same cycle from RUN -> PAUSE only, with no lap toggle.
REQ-040 With STOPWATCH_SATURATE_EN defined, digits 9/9/9 with a tick due -> cnt_en=0, state=11, overflow=1; start_stop is ignored; lap_clr -> IDLE with cnt_clr pulse.
REQ-041 Without STOPWATCH_SATURATE_EN, digits 9/9/9 with a tick due -> cnt_en=1, state stays 01, overflow=0.
